rgen_host_arbiter: RTL and testbench

//  Round-robin arbiter sharing one register block's local command bus among N_HOSTS requesters.

---
 rtl/rgen_host_arbiter_if.sv | 38 +++
 rtl/rgen_host_arbiter.sv | 121 ++++++++++++
 tb/tb_rgen_host_arbiter.sv | 326 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rgen_host_arbiter_if.sv
// Host-side request/response bundle and register-block command bus for rgen_host_arbiter.
interface rgen_host_arbiter_if #(
  parameter int N_HOSTS       = 2,
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 8
);
  logic [N_HOSTS-1:0]               i_host_command_valid;
  logic [N_HOSTS-1:0]               i_host_write;
  logic [N_HOSTS*ADDRESS_WIDTH-1:0] i_host_address;
  logic [N_HOSTS*DATA_WIDTH-1:0]    i_host_write_data;
  logic [N_HOSTS*DATA_WIDTH-1:0]    i_host_write_mask;
  logic [N_HOSTS-1:0]               o_host_response_ready;
  logic [DATA_WIDTH-1:0]            o_host_read_data;
  logic [2:0]                       o_host_status;
  logic                             o_command_valid;
  logic                             o_write;
  logic                             o_read;
  logic [ADDRESS_WIDTH-1:0]         o_address;
  logic [DATA_WIDTH-1:0]            o_write_data;
  logic [DATA_WIDTH-1:0]            o_write_mask;
  logic                             i_response_ready;
  logic [DATA_WIDTH-1:0]            i_read_data;
  logic [2:0]                       i_status;

  modport slave (
    input  i_host_command_valid, i_host_write, i_host_address, i_host_write_data, i_host_write_mask,
    input  i_response_ready, i_read_data, i_status,
    output o_host_response_ready, o_host_read_data, o_host_status,
    output o_command_valid, o_write, o_read, o_address, o_write_data, o_write_mask
  );

  modport master (
    output i_host_command_valid, i_host_write, i_host_address, i_host_write_data, i_host_write_mask,
    output i_response_ready, i_read_data, i_status,
    input  o_host_response_ready, o_host_read_data, o_host_status,
    input  o_command_valid, o_write, o_read, o_address, o_write_data, o_write_mask
  );
endinterface

// File: rtl/rgen_host_arbiter.sv
// Round-robin arbiter serialising N host commands onto one register-block bus,
// with a bounded wait for the block's response.
module rgen_host_arbiter #(
  parameter int         N_HOSTS        = 2,
  parameter int         DATA_WIDTH     = 32,
  parameter int         ADDRESS_WIDTH  = 8,
  parameter int         TIMEOUT_CYCLES = 255,
  parameter logic [2:0] TIMEOUT_STATUS = 3'b010
) (
  input logic               clk,
  input logic               rst,
  rgen_host_arbiter_if.slave bus
);
  localparam int IW = (N_HOSTS > 1) ? $clog2(N_HOSTS) : 1;
  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] TMO_LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic [1:0] {IDLE, BUSY, RESPOND} state_t;

  state_t        state, state_nxt;
  logic [IW-1:0] ptr, grant, pick;
  logic [IW:0]   sum;
  logic          any_req;
  logic [CW-1:0] tmo_cnt;
  logic          timeout_hit, done;

  // First requester at or after the pointer, wrapping around.
  always_comb begin
    pick    = '0;
    any_req = 1'b0;
    sum     = '0;
    for (int i = 0; i < N_HOSTS; i++) begin
      sum = {1'b0, ptr} + (IW+1)'(i);
      if (sum >= (IW+1)'(N_HOSTS)) sum = sum - (IW+1)'(N_HOSTS);
      if (!any_req && bus.i_host_command_valid[sum[IW-1:0]]) begin
        any_req = 1'b1;
        pick    = sum[IW-1:0];
      end
    end
  end

  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (tmo_cnt == TMO_LAST);
  assign done        = bus.i_response_ready || timeout_hit;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = BUSY;
      BUSY:    if (done)    state_nxt = RESPOND;
      RESPOND: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state                     <= IDLE;
      ptr                       <= '0;
      grant                     <= '0;
      tmo_cnt                   <= '0;
      bus.o_command_valid       <= 1'b0;
      bus.o_write               <= 1'b0;
      bus.o_read                <= 1'b0;
      bus.o_address             <= '0;
      bus.o_write_data          <= '0;
      bus.o_write_mask          <= '0;
      bus.o_host_response_ready <= '0;
      bus.o_host_read_data      <= '0;
      bus.o_host_status         <= '0;
    end else begin
      state                     <= state_nxt;
      bus.o_host_response_ready <= '0;
      case (state)
        IDLE: if (any_req) begin
          grant               <= pick;
          tmo_cnt             <= '0;
          bus.o_command_valid <= 1'b1;
          bus.o_write         <= bus.i_host_write[pick];
          bus.o_read          <= ~bus.i_host_write[pick];
          bus.o_address       <= bus.i_host_address[pick*ADDRESS_WIDTH +: ADDRESS_WIDTH];
          bus.o_write_data    <= bus.i_host_write_data[pick*DATA_WIDTH +: DATA_WIDTH];
          bus.o_write_mask    <= bus.i_host_write_mask[pick*DATA_WIDTH +: DATA_WIDTH];
        end
        BUSY: begin
          tmo_cnt <= tmo_cnt + 1'b1;
          // A real response beats a timeout landing on the same cycle.
          if (bus.i_response_ready) begin
            bus.o_host_read_data <= bus.i_read_data;
            bus.o_host_status    <= bus.i_status;
          end else if (timeout_hit) begin
            bus.o_host_read_data <= '0;
            bus.o_host_status    <= TIMEOUT_STATUS;
          end
          if (done) begin
            bus.o_command_valid              <= 1'b0;
            bus.o_write                      <= 1'b0;
            bus.o_read                       <= 1'b0;
            bus.o_address                    <= '0;
            bus.o_write_data                 <= '0;
            bus.o_write_mask                 <= '0;
            bus.o_host_response_ready[grant] <= 1'b1;
          end
        end
        RESPOND: ptr <= (grant == IW'(N_HOSTS-1)) ? '0 : grant + 1'b1;
        default: ;
      endcase
    end
  end

  // Granted host must hold its request unchanged until the response pulse.
  property p_request_held;
    @(posedge clk) disable iff (rst)
      (state == BUSY) |->
        (bus.i_host_command_valid[grant] &&
         bus.i_host_write[grant] == bus.o_write &&
         bus.i_host_address[grant*ADDRESS_WIDTH +: ADDRESS_WIDTH] == bus.o_address &&
         bus.i_host_write_data[grant*DATA_WIDTH +: DATA_WIDTH] == bus.o_write_data &&
         bus.i_host_write_mask[grant*DATA_WIDTH +: DATA_WIDTH] == bus.o_write_mask);
  endproperty
  a_request_held: assert property (p_request_held);
endmodule

// File: tb/tb_rgen_host_arbiter.sv
// Directed and randomised checks of rgen_host_arbiter against a round-robin reference model.
module tb_rgen_host_arbiter;
  localparam int NH  = 2;
  localparam int DW  = 32;
  localparam int AW  = 8;
  localparam int TMO = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  logic          rq_vld  [NH];
  logic          rq_wr   [NH];
  logic [AW-1:0] rq_addr [NH];
  logic [DW-1:0] rq_data [NH];
  logic [DW-1:0] rq_mask [NH];

  rgen_host_arbiter_if #(.N_HOSTS(NH), .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) bus ();

  rgen_host_arbiter #(
    .N_HOSTS(NH), .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW),
    .TIMEOUT_CYCLES(TMO), .TIMEOUT_STATUS(3'b010)
  ) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic apply();
    for (int h = 0; h < NH; h++) begin
      bus.i_host_command_valid[h]        = rq_vld[h];
      bus.i_host_write[h]                = rq_wr[h];
      bus.i_host_address[h*AW +: AW]     = rq_addr[h];
      bus.i_host_write_data[h*DW +: DW]  = rq_data[h];
      bus.i_host_write_mask[h*DW +: DW]  = rq_mask[h];
    end
  endtask

  task automatic set_req(input int h, input logic wr, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [DW-1:0] m);
    rq_vld[h] = 1'b1; rq_wr[h] = wr; rq_addr[h] = a; rq_data[h] = d; rq_mask[h] = m;
  endtask

  task automatic respond(input logic rdy, input logic [DW-1:0] d, input logic [2:0] s);
    bus.i_response_ready = rdy; bus.i_read_data = d; bus.i_status = s;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    for (int h = 0; h < NH; h++) rq_vld[h] = 1'b0;
    apply(); respond(1'b0, '0, '0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    for (int h = 0; h < NH; h++) begin
      rq_vld[h] = 1'b0; rq_wr[h] = 1'b0; rq_addr[h] = '0; rq_data[h] = '0; rq_mask[h] = '0;
    end
    apply(); respond(1'b0, '0, '0);
    repeat (3) @(negedge clk);
    n_checks++;
    if ({bus.o_command_valid, bus.o_write, bus.o_read, bus.o_address, bus.o_write_data, bus.o_write_mask,
         bus.o_host_response_ready, bus.o_host_read_data, bus.o_host_status} !== '0) begin
      n_fail++; $display("FAIL reset_outputs: some output nonzero, cv=%b pulse=%b rd=%h st=%b, required all 0",
                         bus.o_command_valid, bus.o_host_response_ready, bus.o_host_read_data, bus.o_host_status);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({bus.o_command_valid, bus.o_host_response_ready} !== '0) begin
      n_fail++; $display("FAIL idle_no_request: cv=%b pulse=%b, required 0/00", bus.o_command_valid, bus.o_host_response_ready);
    end
  endtask

  task automatic test_single_read();
    set_req(1, 1'b0, 8'h04, 32'h0, 32'h0); apply();
    @(negedge clk);
    n_checks++;
    if ({bus.o_command_valid, bus.o_read, bus.o_write, bus.o_address} !== {1'b1, 1'b1, 1'b0, 8'h04}) begin
      n_fail++; $display("FAIL read_cmd: cv=%b rd=%b wr=%b addr=%h, required 1 1 0 04",
                         bus.o_command_valid, bus.o_read, bus.o_write, bus.o_address);
    end
    @(negedge clk);
    n_checks++;
    if ({bus.o_command_valid, bus.o_host_response_ready} !== {1'b1, 2'b00}) begin
      n_fail++; $display("FAIL read_busy2: cv=%b pulse=%b, required 1/00", bus.o_command_valid, bus.o_host_response_ready);
    end
    respond(1'b1, 32'hCAFE0001, 3'b000);
    @(negedge clk);
    n_checks++;
    if ({bus.o_host_response_ready, bus.o_host_read_data, bus.o_host_status, bus.o_command_valid} !==
        {2'b10, 32'hCAFE0001, 3'b000, 1'b0}) begin
      n_fail++; $display("FAIL read_resp: pulse=%b rd=%h st=%b cv=%b, required 10 cafe0001 000 0",
                         bus.o_host_response_ready, bus.o_host_read_data, bus.o_host_status, bus.o_command_valid);
    end
    rq_vld[1] = 1'b0; apply(); respond(1'b0, 32'h1111_2222, 3'b111);
    @(negedge clk);
    n_checks++;
    if ({bus.o_host_response_ready, bus.o_host_read_data} !== {2'b00, 32'hCAFE0001}) begin
      n_fail++; $display("FAIL read_hold: pulse=%b rd=%h, required 00 cafe0001", bus.o_host_response_ready, bus.o_host_read_data);
    end
  endtask

  task automatic test_contention();
    int exp_h [3] = '{0, 1, 0};
    logic [NH-1:0] exp_p;
    do_reset();
    set_req(0, 1'b0, 8'h10, '0, '0);
    set_req(1, 1'b0, 8'h20, '0, '0);
    apply();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_checks++;
      if ({bus.o_command_valid, bus.o_address} !== {1'b1, rq_addr[exp_h[k]]}) begin
        n_fail++; $display("FAIL contention_grant%0d: cv=%b addr=%h, required 1 %h",
                           k, bus.o_command_valid, bus.o_address, rq_addr[exp_h[k]]);
      end
      respond(1'b1, 32'hA0 + k, 3'b000);
      @(negedge clk);
      exp_p = '0; exp_p[exp_h[k]] = 1'b1;
      n_checks++;
      if ({bus.o_host_response_ready, bus.o_host_read_data} !== {exp_p, 32'hA0 + k}) begin
        n_fail++; $display("FAIL contention_resp%0d: pulse=%b rd=%h, required %b %h",
                           k, bus.o_host_response_ready, bus.o_host_read_data, exp_p, 32'hA0 + k);
      end
      rq_vld[exp_h[k]] = 1'b0; apply(); respond(1'b0, '0, '0);
      @(negedge clk);
      if (k == 0) begin rq_vld[0] = 1'b1; apply(); end
    end
  endtask

  task automatic test_write();
    set_req(0, 1'b1, 8'h08, 32'h12345678, 32'h0000FFFF); apply();
    for (int b = 1; b <= 3; b++) begin
      @(negedge clk);
      n_checks++;
      if ({bus.o_command_valid, bus.o_write, bus.o_read, bus.o_address, bus.o_write_data, bus.o_write_mask} !==
          {1'b1, 1'b1, 1'b0, 8'h08, 32'h12345678, 32'h0000FFFF}) begin
        n_fail++; $display("FAIL write_busy%0d: cv=%b wr=%b rd=%b addr=%h d=%h m=%h, required 1 1 0 08 12345678 0000ffff",
                           b, bus.o_command_valid, bus.o_write, bus.o_read, bus.o_address, bus.o_write_data, bus.o_write_mask);
      end
      if (b == 3) respond(1'b1, 32'h55, 3'b000);
    end
    @(negedge clk);
    n_checks++;
    if ({bus.o_host_response_ready, bus.o_command_valid} !== {2'b01, 1'b0}) begin
      n_fail++; $display("FAIL write_resp: pulse=%b cv=%b, required 01 0", bus.o_host_response_ready, bus.o_command_valid);
    end
    rq_vld[0] = 1'b0; apply(); respond(1'b0, '0, '0);
    @(negedge clk);
  endtask

  task automatic test_timeout();
    int n = 0;
    set_req(1, 1'b0, 8'h30, '0, '0); apply();
    respond(1'b0, 32'hDEADBEEF, 3'b111);
    @(negedge clk);
    while (bus.o_command_valid && n < 20) begin n++; @(negedge clk); end
    n_checks++;
    if (n != TMO) begin
      n_fail++; $display("FAIL timeout_len: command_valid high %0d cycles, required %0d", n, TMO);
    end
    n_checks++;
    if ({bus.o_host_response_ready, bus.o_host_read_data, bus.o_host_status} !== {2'b10, 32'h0, 3'b010}) begin
      n_fail++; $display("FAIL timeout_resp: pulse=%b rd=%h st=%b, required 10 00000000 010",
                         bus.o_host_response_ready, bus.o_host_read_data, bus.o_host_status);
    end
    rq_vld[1] = 1'b0; apply(); respond(1'b0, '0, '0);
    @(negedge clk);
  endtask

  task automatic test_same_cycle();
    int n = 0;
    set_req(0, 1'b0, 8'h40, '0, '0); apply();
    @(negedge clk);
    while (bus.o_command_valid && n < 20) begin
      n++;
      if (n == TMO) respond(1'b1, 32'hBEEF0042, 3'b101);
      @(negedge clk);
    end
    n_checks++;
    if (n != TMO) begin
      n_fail++; $display("FAIL same_cycle_len: command_valid high %0d cycles, required %0d", n, TMO);
    end
    n_checks++;
    if ({bus.o_host_response_ready, bus.o_host_read_data, bus.o_host_status} !== {2'b01, 32'hBEEF0042, 3'b101}) begin
      n_fail++; $display("FAIL same_cycle_resp: pulse=%b rd=%h st=%b, required 01 beef0042 101",
                         bus.o_host_response_ready, bus.o_host_read_data, bus.o_host_status);
    end
    rq_vld[0] = 1'b0; apply(); respond(1'b0, '0, '0);
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    // Host0 was served last, so host1 is next in line before the reset.
    set_req(0, 1'b0, 8'h50, '0, '0);
    set_req(1, 1'b0, 8'h60, '0, '0);
    apply();
    @(negedge clk);
    n_checks++;
    if ({bus.o_command_valid, bus.o_address} !== {1'b1, 8'h60}) begin
      n_fail++; $display("FAIL rstmid_pre_grant: cv=%b addr=%h, required 1 60", bus.o_command_valid, bus.o_address);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({bus.o_command_valid, bus.o_write, bus.o_read, bus.o_address, bus.o_write_data, bus.o_write_mask,
         bus.o_host_response_ready, bus.o_host_read_data, bus.o_host_status} !== '0) begin
      n_fail++; $display("FAIL rstmid_outputs: cv=%b addr=%h pulse=%b rd=%h st=%b, required all 0",
                         bus.o_command_valid, bus.o_address, bus.o_host_response_ready, bus.o_host_read_data, bus.o_host_status);
    end
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({bus.o_command_valid, bus.o_address, bus.o_host_response_ready} !== {1'b1, 8'h50, 2'b00}) begin
      n_fail++; $display("FAIL rstmid_regrant: cv=%b addr=%h pulse=%b, required 1 50 00",
                         bus.o_command_valid, bus.o_address, bus.o_host_response_ready);
    end
    respond(1'b1, 32'h77, 3'b001);
    @(negedge clk);
    n_checks++;
    if ({bus.o_host_response_ready, bus.o_host_read_data, bus.o_host_status} !== {2'b01, 32'h77, 3'b001}) begin
      n_fail++; $display("FAIL rstmid_resp: pulse=%b rd=%h st=%b, required 01 00000077 001",
                         bus.o_host_response_ready, bus.o_host_read_data, bus.o_host_status);
    end
    rq_vld[0] = 1'b0; rq_vld[1] = 1'b0; apply(); respond(1'b0, '0, '0);
    @(negedge clk);
  endtask

  // Reference: pending set per host, round-robin pick from a pointer, response
  // decided by the random latency versus the timeout limit.
  task automatic test_random();
    int phase = 0;  // 0 idle, 1 busy, 2 gap after response
    int ptr_m = 0, g = 0, busy_n = 0, lat = 0;
    logic resolve = 1'b0;
    logic [NH-1:0] snap, exp_p;
    logic [DW-1:0] exp_d = '0;
    logic [2:0] exp_s = '0;
    do_reset();
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(negedge clk);
      snap = bus.i_host_command_valid;
      if (phase == 0) begin
        if (snap != '0) begin
          g = -1;
          for (int k = 0; k < NH; k++)
            if (g < 0 && snap[(ptr_m + k) % NH]) g = (ptr_m + k) % NH;
          n_checks++;
          if ({bus.o_command_valid, bus.o_write, bus.o_read, bus.o_address, bus.o_write_data, bus.o_write_mask} !==
              {1'b1, rq_wr[g], ~rq_wr[g], rq_addr[g], rq_data[g], rq_mask[g]}) begin
            n_fail++; $display("FAIL rand_grant c%0d: cv=%b wr=%b addr=%h, required host%0d 1 %b %h",
                               cyc, bus.o_command_valid, bus.o_write, bus.o_address, g, rq_wr[g], rq_addr[g]);
          end
          busy_n = 1; lat = $urandom_range(1, 6); phase = 1;
        end else begin
          n_checks++;
          if ({bus.o_command_valid, bus.o_host_response_ready} !== '0) begin
            n_fail++; $display("FAIL rand_idle c%0d: cv=%b pulse=%b, required 0 00",
                               cyc, bus.o_command_valid, bus.o_host_response_ready);
          end
        end
      end else if (phase == 1) begin
        if (resolve) begin
          exp_p = '0; exp_p[g] = 1'b1;
          n_checks++;
          if ({bus.o_host_response_ready, bus.o_command_valid, bus.o_host_read_data, bus.o_host_status} !==
              {exp_p, 1'b0, exp_d, exp_s}) begin
            n_fail++; $display("FAIL rand_resp c%0d: pulse=%b cv=%b rd=%h st=%b, required %b 0 %h %b",
                               cyc, bus.o_host_response_ready, bus.o_command_valid, bus.o_host_read_data,
                               bus.o_host_status, exp_p, exp_d, exp_s);
          end
          rq_vld[g] = 1'b0;
          ptr_m = (g + 1) % NH;
          phase = 2;
        end else begin
          busy_n++;
          n_checks++;
          if ({bus.o_command_valid, bus.o_host_response_ready, bus.o_address, bus.o_write_data} !==
              {1'b1, {NH{1'b0}}, rq_addr[g], rq_data[g]}) begin
            n_fail++; $display("FAIL rand_busy c%0d: cv=%b pulse=%b addr=%h, required 1 00 %h",
                               cyc, bus.o_command_valid, bus.o_host_response_ready, bus.o_address, rq_addr[g]);
          end
        end
      end else begin
        n_checks++;
        if ({bus.o_command_valid, bus.o_host_response_ready} !== '0) begin
          n_fail++; $display("FAIL rand_gap c%0d: cv=%b pulse=%b, required 0 00",
                             cyc, bus.o_command_valid, bus.o_host_response_ready);
        end
        phase = 0;
      end
      resolve = 1'b0;
      if (phase == 1) begin
        if (busy_n == lat) begin
          respond(1'b1, $urandom, 3'($urandom));
          exp_d = bus.i_read_data; exp_s = bus.i_status; resolve = 1'b1;
        end else begin
          respond(1'b0, $urandom, 3'($urandom));
          if (busy_n == TMO) begin exp_d = '0; exp_s = 3'b010; resolve = 1'b1; end
        end
      end else begin
        respond(1'b0, $urandom, 3'($urandom));
      end
      for (int h = 0; h < NH; h++)
        if (!rq_vld[h] && !(phase == 2 && h == g) && $urandom_range(0, 2) == 0)
          set_req(h, 1'($urandom), 8'($urandom), $urandom, $urandom);
      apply();
    end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_contention();
    test_write();
    test_timeout();
    test_same_cycle();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
